// File: rtl/shift_reg_sipo.sv
// Serial-in, parallel-out shift register with elaboration-time shift direction
// and a configurable asynchronous reset value.
module shift_reg_sipo #(
  parameter int               WIDTH        = 4,
  parameter bit               MSB_FIRST_IN = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // The entry bit is fixed at elaboration; sdi is taken as-is, X/Z included.
  generate
    if (MSB_FIRST_IN) begin : g_msb_first
      assign shift_d = {sdi, shift_q[WIDTH-1:1]};
    end else begin : g_lsb_first
      assign shift_d = {shift_q[WIDTH-2:0], sdi};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= RESET_VALUE;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q = shift_q;

endmodule

// File: tb/tb_shift_reg_sipo.sv
// Scoreboard bench for shift_reg_sipo: three instances share clk/reset_n/sdi and
// are checked against a bit-history model after every rising edge.
`timescale 1ns/1ps
module tb_shift_reg_sipo;

  localparam int WA = 4;
  localparam int WB = 8;
  localparam int WC = 5;
  localparam logic [WA-1:0] RV_A = '0;
  localparam logic [WB-1:0] RV_B = '0;
  localparam logic [WC-1:0] RV_C = 5'b10110;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  logic sdi;
  logic [WA-1:0] q_a;
  logic [WB-1:0] q_b;
  logic [WC-1:0] q_c;

  initial begin
    clk = 1'b0;
    forever #500 clk = ~clk;
  end

  shift_reg_sipo dut_a (.clk(clk), .reset_n(reset_n), .sdi(sdi), .q(q_a));

  shift_reg_sipo #(.WIDTH(WB), .MSB_FIRST_IN(1'b0), .RESET_VALUE(RV_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .sdi(sdi), .q(q_b)
  );

  shift_reg_sipo #(.WIDTH(WC), .MSB_FIRST_IN(1'b1), .RESET_VALUE(RV_C)) dut_c (
    .clk(clk), .reset_n(reset_n), .sdi(sdi), .q(q_c)
  );

  // ---------------- reference model ----------------
  // Each history queue holds bits ordered from the entry position (index 0)
  // to the exit position; the newest sample is always at index 0.
  logic hist_a[$];
  logic hist_b[$];
  logic hist_c[$];

  logic [WA-1:0] exp_a[$];
  logic [WB-1:0] exp_b[$];
  logic [WC-1:0] exp_c[$];

  int  tests  = 0;
  int  failed = 0;
  bit  check_en = 1'b0;

  function automatic logic [63:0] to_word(input logic h[$], input int w, input bit msb_first);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < w; k++) begin
      if (msb_first) r[w-1-k] = h[k];
      else           r[k]     = h[k];
    end
    return r;
  endfunction

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    hist_c.delete();
    for (int k = 0; k < WA; k++) hist_a.push_back(RV_A[WA-1-k]);
    for (int k = 0; k < WB; k++) hist_b.push_back(RV_B[k]);
    for (int k = 0; k < WC; k++) hist_c.push_back(RV_C[WC-1-k]);
  endtask

  task automatic model_shift(input logic b);
    logic [63:0] w;
    hist_a.push_front(b); void'(hist_a.pop_back());
    hist_b.push_front(b); void'(hist_b.pop_back());
    hist_c.push_front(b); void'(hist_c.pop_back());
    w = to_word(hist_a, WA, 1'b1); exp_a.push_back(w[WA-1:0]);
    w = to_word(hist_b, WB, 1'b0); exp_b.push_back(w[WB-1:0]);
    w = to_word(hist_c, WC, 1'b1); exp_c.push_back(w[WC-1:0]);
  endtask

  task automatic check_now(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_now({tag, "_a"}, 64'(q_a), 64'(RV_A));
    check_now({tag, "_b"}, 64'(q_b), 64'(RV_B));
    check_now({tag, "_c"}, 64'(q_c), 64'(RV_C));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      if (exp_a.size() == 0) check_now("underflow_a", 64'(q_a), 64'hDEAD);
      else                   check_now("shift_a", 64'(q_a), 64'(exp_a.pop_front()));
      if (exp_b.size() == 0) check_now("underflow_b", 64'(q_b), 64'hDEAD);
      else                   check_now("shift_b", 64'(q_b), 64'(exp_b.pop_front()));
      if (exp_c.size() == 0) check_now("underflow_c", 64'(q_c), 64'hDEAD);
      else                   check_now("shift_c", 64'(q_c), 64'(exp_c.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    @(negedge clk);
    sdi = b;
    model_shift(b);
  endtask

  // 0.3 us low pulse placed between edges; the following edge shifts b in.
  task automatic reset_pulse(input logic b);
    @(negedge clk);
    #100 reset_n = 1'b0;
    #50  check_reset_values("rst_async");
    sdi = ~b;
    #200 check_reset_values("rst_hold");
    #50  reset_n = 1'b1;
    #10  check_reset_values("rst_release");
    model_reset();
    sdi = b;
    model_shift(b);
  endtask

  task automatic drive_zeros(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b1;
    sdi     = 1'b0;
    // Scenario 1: reset low 1.0 us .. 2.3 us with sdi = 0.
    #1000 reset_n = 1'b0;
    #100  check_reset_values("s1_async");
    #500  check_reset_values("s1_hold_edge");
    #700  reset_n = 1'b1;
    #10   check_reset_values("s1_release");
    model_reset();
    sdi = 1'b0;
    model_shift(1'b0);
    check_en = 1'b1;
    drive_zeros(2);

    // Scenario 2 / 6: single one-clock pulse.
    drive_bit(1'b1);
    drive_zeros(WB + 1);

    // Scenario 3: two consecutive ones.
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_zeros(WB + 1);

    // Scenario 4: 1,0,1.
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_zeros(WB + 1);

    // Scenario 5: fill with ones, then asynchronous reset mid-stream.
    for (int i = 0; i < WB; i++) drive_bit(1'b1);
    reset_pulse(1'b0);
    drive_bit(1'b1);
    drive_zeros(3);

    // Unknown input propagates untouched and is then flushed out.
    drive_bit(1'bx);
    drive_zeros(WB + 1);

    // Randomized stream with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) reset_pulse(1'($urandom_range(0, 1)));
      else                            drive_bit(1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    #2;
    check_en = 1'b0;
    check_now("leftover_a", 64'(exp_a.size()), 64'd0);
    check_now("leftover_b", 64'(exp_b.size()), 64'd0);
    check_now("leftover_c", 64'(exp_c.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/shift_reg_sipo.md
SHIFT_REG_SIPO -- requirements
Module: shift_reg_sipo

Interface
REQ-001 The parameter WIDTH SHALL default to 4 and set the register length and the width of q; legal values are 2 to 64.
REQ-002 The parameter MSB_FIRST_IN SHALL default to 1; when 1, sdi enters q[WIDTH-1] and data moves toward q[0]; when 0, sdi enters q[0] and data moves toward q[WIDTH-1].
REQ-003 The parameter RESET_VALUE SHALL default to all zeros and set the value q takes during reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sdi  input  1  serial data in, sampled on each rising clk edge.
REQ-007 q  output  WIDTH  parallel register contents, driven directly from flops with no combinational path from sdi.

Function
REQ-008 The block SHALL contain one WIDTH-bit shift register and no other state.
REQ-009 With MSB_FIRST_IN=1, on each rising clk edge with reset_n=1, q SHALL take {sdi, q[WIDTH-1:1]}.
REQ-010 With MSB_FIRST_IN=0, on each rising clk edge with reset_n=1, q SHALL take {q[WIDTH-2:0], sdi}.
REQ-011 The block SHALL shift on every clock edge, with no enable and no hold condition.
REQ-012 Latency: a bit sampled at edge N SHALL appear at the entry bit of q after edge N and at the exit bit after edge N+WIDTH-1.
REQ-013 After edge N+WIDTH, that bit SHALL be discarded; no serial output or overflow flag exists.
REQ-014 An X or Z on sdi SHALL propagate as-is into the register; the block does no input sanitising.
REQ-015 The block SHALL have no parallel load and no bidirectional shift at run time; direction is fixed by MSB_FIRST_IN at elaboration.

Reset
REQ-016 When reset_n goes low, q SHALL go to RESET_VALUE immediately, independent of clk.
REQ-017 While reset_n is low, q SHALL hold RESET_VALUE and ignore sdi and clk edges.
REQ-018 On the first rising clk edge after reset_n goes high, normal shifting SHALL resume; that edge SHALL shift sdi into RESET_VALUE.
REQ-019 Reset asserted mid-stream SHALL discard all in-flight bits; no history survives reset.
REQ-020 Reset release need not be synchronous to clk; the bench releases reset at a non-edge time.

Verification
REQ-021 Scenario 1: clk period 1 us, reset_n low from t=1 us to t=2.3 us with sdi=0 -> q=4'b0000 during reset and after 2 further edges.
REQ-022 Scenario 2: single 1-clock pulse, sdi=1 for one edge then 0 -> q sequences 1000, 0100, 0010, 0001, then 0000.
REQ-023 Scenario 3: sdi=1 for 2 edges -> q sequences 1000, 1100, 0110, 0011, 0001, 0000.
REQ-024 Scenario 4: pattern 1,0,1 on 3 consecutive edges, then 0 -> q sequences 1000, 0100, 1010, 0101, 0010, 0001, 0000.
REQ-025 Scenario 5: fill with 1111, then pulse reset_n low for 0.3 us between edges -> q drops to 0000 asynchronously before the next edge, and shifting resumes on the first edge after release.
REQ-026 Scenario 6: MSB_FIRST_IN=0 with WIDTH=8 and a single 1 pulse -> q sequences 0x01, 0x02, ... 0x80, then 0x00.
